// File: rtl/edge_detector_bank_pkg.sv
// rtl/edge_detector_bank_pkg.sv - shared mode constants and warm-up length helper (EDGE_DET_FILTER_EN aware)
package edge_detector_bank_pkg;

    localparam int EDGE_MODE_FALL = 0;
    localparam int EDGE_MODE_RISE = 1;
    localparam int EDGE_MODE_BOTH = 2;

`ifdef EDGE_DET_FILTER_EN
    localparam bit c_FILTER_ON = 1'b1;
`else
    localparam bit c_FILTER_ON = 1'b0;
`endif

    // Cycles before s is trustworthy after reset; the debounce stage adds its own settle time
    // so a channel already high at reset release still yields no spurious rise.
    function automatic int warmup_cycles(input int sync_stages, input int filter_len);
        return sync_stages + 1 + (c_FILTER_ON ? filter_len : 0);
    endfunction

endpackage

// File: rtl/edge_detector_bank_sync_filter.sv
// rtl/edge_detector_bank_sync_filter.sv - one channel: synchroniser chain plus optional debounce (EDGE_DET_FILTER_EN)
module edge_sync_filter #(
    parameter int p_SYNC_STAGES = 2
`ifdef EDGE_DET_FILTER_EN
    ,
    parameter int p_FILTER_LEN  = 4
`endif
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_data,
    output logic o_s
);

    logic [p_SYNC_STAGES-1:0] r_sync;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[p_SYNC_STAGES-2:0], i_data};
        end
    end

`ifdef EDGE_DET_FILTER_EN
    localparam int c_CNT_W = $clog2(p_FILTER_LEN + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_s;

    // Accept a new level only after it has differed from s for p_FILTER_LEN samples in a row
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_s   <= 1'b0;
        end else if (r_sync[p_SYNC_STAGES-1] == r_s) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_W'(p_FILTER_LEN - 1)) begin
            r_s   <= r_sync[p_SYNC_STAGES-1];
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_s = r_s;
`else
    assign o_s = r_sync[p_SYNC_STAGES-1];
`endif

endmodule

// File: rtl/edge_detector_bank.sv
// rtl/edge_detector_bank.sv - multi-channel synchronised edge detector with sticky pending flags (EDGE_DET_FILTER_EN)
module edge_detector_bank
    import edge_detector_bank_pkg::*;
#(
    parameter int p_CHANNELS    = 8,
    parameter int p_MODE        = EDGE_MODE_RISE,
    parameter int p_SYNC_STAGES = 2,
    parameter int p_FILTER_LEN  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [p_CHANNELS-1:0] i_data,
    input  logic [p_CHANNELS-1:0] i_clear,
    output logic [p_CHANNELS-1:0] o_rise,
    output logic [p_CHANNELS-1:0] o_fall,
    output logic [p_CHANNELS-1:0] o_edge,
    output logic [p_CHANNELS-1:0] o_pending,
    output logic                  o_any
);

    localparam int c_WARM   = warmup_cycles(p_SYNC_STAGES, p_FILTER_LEN);
    localparam int c_WARM_W = $clog2(c_WARM + 1);

    logic [p_CHANNELS-1:0] w_s;
    logic [p_CHANNELS-1:0] r_prev;
    logic [c_WARM_W-1:0]   r_warm;
    logic                  w_live;
    logic [p_CHANNELS-1:0] w_rise;
    logic [p_CHANNELS-1:0] w_fall;
    logic [p_CHANNELS-1:0] w_pend_next;
    logic [p_CHANNELS-1:0] r_rise;
    logic [p_CHANNELS-1:0] r_fall;
    logic [p_CHANNELS-1:0] r_edge;
    logic [p_CHANNELS-1:0] r_pending;
    logic                  r_any;

    for (genvar g = 0; g < p_CHANNELS; g++) begin : g_ch
`ifdef EDGE_DET_FILTER_EN
        edge_sync_filter #(
            .p_SYNC_STAGES(p_SYNC_STAGES),
            .p_FILTER_LEN (p_FILTER_LEN)
        ) u_ch (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_data (i_data[g]),
            .o_s    (w_s[g])
        );
`else
        edge_sync_filter #(
            .p_SYNC_STAGES(p_SYNC_STAGES)
        ) u_ch (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_data (i_data[g]),
            .o_s    (w_s[g])
        );
`endif
    end

    assign w_live = (r_warm == c_WARM_W'(c_WARM));

    // Saturating warm-up counter; edges are only reported once it reaches its terminal value
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_warm <= '0;
        end else if (!w_live) begin
            r_warm <= r_warm + 1'b1;
        end
    end

    // Previous sample follows s unconditionally so warm-up leaves it aligned with the input
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_s;
        end
    end

    // Edge decode, masked by mode and by warm-up
    always_comb begin
        w_rise = '0;
        w_fall = '0;
        if (w_live) begin
            if (p_MODE != EDGE_MODE_FALL) w_rise = w_s & ~r_prev;
            if (p_MODE != EDGE_MODE_RISE) w_fall = ~w_s & r_prev;
        end
    end

    // A new edge beats a same-cycle clear on its channel
    assign w_pend_next = (r_pending & ~i_clear) | r_edge;

    // Registered pulse, pending and summary outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rise    <= '0;
            r_fall    <= '0;
            r_edge    <= '0;
            r_pending <= '0;
            r_any     <= 1'b0;
        end else begin
            r_rise    <= w_rise;
            r_fall    <= w_fall;
            r_edge    <= w_rise | w_fall;
            r_pending <= w_pend_next;
            r_any     <= |w_pend_next;
        end
    end

    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
    assign o_edge    = r_edge;
    assign o_pending = r_pending;
    assign o_any     = r_any;

endmodule
